// File: rtl/gsim_pkg.sv
// Shared constants and types for the Gauss-Seidel sequencer and its neighbour mux.
// x values are 16.16 signed fixed point; b values are 16-bit signed integers.
package gsim_pkg;

    localparam int N_UNK = 16;
    localparam int IDXW  = $clog2(N_UNK);

    localparam int FRAC = 16;
    localparam int XW   = 32;
    localparam int BW   = 16;

    // Band coefficients applied by the external update cell (diagonal, then off-diagonals 1..3).
    localparam int BAND_DIAG = 20;
    localparam int BAND_OFF1 = 13;
    localparam int BAND_OFF2 = 6;
    localparam int BAND_OFF3 = 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        WAIT,
        OUT
    } state_e;

endpackage

// File: rtl/gsim_nbr_mux.sv
// Selects x[k-3..k-1] and x[k+1..k+3] from the register file for the issued index.
// Neighbours that fall outside 0..N_UNK-1 read as zero.
module gsim_nbr_mux
    import gsim_pkg::*;
(
    input  logic [XW-1:0]   x [N_UNK],
    input  logic [IDXW-1:0] k,
    output logic [XW-1:0]   prd3,
    output logic [XW-1:0]   prd2,
    output logic [XW-1:0]   prd1,
    output logic [XW-1:0]   suc1,
    output logic [XW-1:0]   suc2,
    output logic [XW-1:0]   suc3
);

    // The index arithmetic wraps in IDXW bits; the range test masks the wrapped cases.
    assign prd1 = (k >= IDXW'(1)) ? x[k - IDXW'(1)] : '0;
    assign prd2 = (k >= IDXW'(2)) ? x[k - IDXW'(2)] : '0;
    assign prd3 = (k >= IDXW'(3)) ? x[k - IDXW'(3)] : '0;

    assign suc1 = (k <= IDXW'(N_UNK - 2)) ? x[k + IDXW'(1)] : '0;
    assign suc2 = (k <= IDXW'(N_UNK - 3)) ? x[k + IDXW'(2)] : '0;
    assign suc3 = (k <= IDXW'(N_UNK - 4)) ? x[k + IDXW'(3)] : '0;

endmodule

// File: rtl/gsim_ctrl.sv
// Gauss-Seidel sequencer: loads b, issues one x-update at a time to the shared cell,
// writes each result back before the next issue, and streams x out after N_ITER sweeps.
module gsim_ctrl
    import gsim_pkg::*;
#(
    parameter int N_ITER = 100,
    parameter int ITW    = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_en,
    input  logic [BW-1:0] b_in,
    output logic          busy,
    output logic          alu_req,
    output logic [BW-1:0] alu_b,
    output logic [XW-1:0] alu_prd3,
    output logic [XW-1:0] alu_prd2,
    output logic [XW-1:0] alu_prd1,
    output logic [XW-1:0] alu_suc1,
    output logic [XW-1:0] alu_suc2,
    output logic [XW-1:0] alu_suc3,
    input  logic          alu_done,
    input  logic [XW-1:0] alu_x,
    output logic          out_valid,
    output logic [XW-1:0] x_out
);

    localparam logic [IDXW-1:0] LAST_IDX   = IDXW'(N_UNK - 1);
    localparam logic [ITW-1:0]  LAST_SWEEP = ITW'(N_ITER - 1);

    state_e          state_q, state_d;
    logic [BW-1:0]   b_q [N_UNK];
    logic [BW-1:0]   b_d [N_UNK];
    logic [XW-1:0]   x_q [N_UNK];
    logic [XW-1:0]   x_d [N_UNK];
    logic [IDXW-1:0] wr_idx_q, wr_idx_d;
    logic [IDXW-1:0] k_q, k_d;
    logic [IDXW-1:0] out_idx_q, out_idx_d;
    logic [ITW-1:0]  sweep_q, sweep_d;

    logic [XW-1:0] nbr_prd3, nbr_prd2, nbr_prd1;
    logic [XW-1:0] nbr_suc1, nbr_suc2, nbr_suc3;
    logic          op_en;

    gsim_nbr_mux u_nbr (
        .x    (x_q),
        .k    (k_q),
        .prd3 (nbr_prd3),
        .prd2 (nbr_prd2),
        .prd1 (nbr_prd1),
        .suc1 (nbr_suc1),
        .suc2 (nbr_suc2),
        .suc3 (nbr_suc3)
    );

    always_comb begin
        state_d   = state_q;
        b_d       = b_q;
        x_d       = x_q;
        wr_idx_d  = wr_idx_q;
        k_d       = k_q;
        out_idx_d = out_idx_q;
        sweep_d   = sweep_q;

        case (state_q)
            IDLE: begin
                // A new job always starts from x = 0, whatever the previous job left behind.
                if (in_en) begin
                    b_d[0] = b_in;
                    for (int i = 0; i < N_UNK; i++) begin
                        x_d[i] = '0;
                    end
                    wr_idx_d = IDXW'(1);
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                if (in_en) begin
                    b_d[wr_idx_q] = b_in;
                    wr_idx_d      = wr_idx_q + IDXW'(1);
                    if (wr_idx_q == LAST_IDX) begin
                        k_d     = '0;
                        sweep_d = '0;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (alu_done) begin
                    x_d[k_q] = alu_x;
                    if (k_q != LAST_IDX) begin
                        k_d     = k_q + IDXW'(1);
                        state_d = ISSUE;
                    end else begin
                        k_d = '0;
                        if (sweep_q == LAST_SWEEP) begin
                            out_idx_d = '0;
                            state_d   = OUT;
                        end else begin
                            sweep_d = sweep_q + ITW'(1);
                            state_d = ISSUE;
                        end
                    end
                end
            end
            OUT: begin
                out_idx_d = out_idx_q + IDXW'(1);
                if (out_idx_q == LAST_IDX) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            wr_idx_q  <= '0;
            k_q       <= '0;
            out_idx_q <= '0;
            sweep_q   <= '0;
            for (int i = 0; i < N_UNK; i++) begin
                b_q[i] <= '0;
                x_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            wr_idx_q  <= wr_idx_d;
            k_q       <= k_d;
            out_idx_q <= out_idx_d;
            sweep_q   <= sweep_d;
            b_q       <= b_d;
            x_q       <= x_d;
        end
    end

    // Operands stay valid through WAIT so the cell may sample them late; elsewhere they read zero.
    assign op_en     = (state_q == ISSUE) || (state_q == WAIT);
    assign busy      = (state_q != IDLE);
    assign alu_req   = (state_q == ISSUE);
    assign alu_b     = op_en ? b_q[k_q] : '0;
    assign alu_prd3  = op_en ? nbr_prd3 : '0;
    assign alu_prd2  = op_en ? nbr_prd2 : '0;
    assign alu_prd1  = op_en ? nbr_prd1 : '0;
    assign alu_suc1  = op_en ? nbr_suc1 : '0;
    assign alu_suc2  = op_en ? nbr_suc2 : '0;
    assign alu_suc3  = op_en ? nbr_suc3 : '0;
    assign out_valid = (state_q == OUT);
    assign x_out     = out_valid ? x_q[out_idx_q] : '0;

endmodule
